serial_frame_deserializer: RTL and testbench

SERIAL_FRAME_DESERIALIZER -- requirements
Module: serial_frame_deserializer

---
 rtl/serial_frame_deserializer.sv | 204 ++++++++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//   Hunts a serial bit stream for SYNC_WORD (MSB first). Once the pattern is
//   found it collects FRAME_WORDS payload words of DATA_WIDTH bits each and
//   presents each word on a one-deep valid/ready output register.
//   Optional build macro: PARITY_CHECK_EN -- every payload word is followed by
//   one even-parity bit, and parity_err flags a mismatch for that word.
//
//   Output handshake: dout/dout_last/parity_err are valid while dout_valid=1
//   and hold stable until a cycle with dout_valid=1 and dout_ready=1 transfers
//   the word. A word that completes while the register is occupied and not
//   being drained is dropped and reported by a one-cycle overflow pulse.
module serial_frame_deserializer #(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    SYNC_WIDTH  = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = 8'hA5,
   parameter int                    FRAME_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din,
   input  logic                  din_valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  dout_last,
   output logic                  parity_err,
   output logic                  overflow,
   output logic                  in_frame
);

`ifdef PARITY_CHECK_EN
   localparam int WORD_BITS = DATA_WIDTH + 1;
`else
   localparam int WORD_BITS = DATA_WIDTH;
`endif
   localparam int BCW = $clog2(WORD_BITS + 1);
   localparam int WCW = $clog2(FRAME_WORDS + 1);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_BITS - 1);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

   typedef enum logic {
      S_HUNT    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [SYNC_WIDTH-1:0] r_hist;
   logic [DATA_WIDTH-1:0] r_word;
   logic [BCW-1:0]        r_bit_cnt;
   logic [WCW-1:0]        r_word_cnt;
`ifdef PARITY_CHECK_EN
   logic                  r_par;
`endif

   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;
   logic                  r_dout_last;
   logic                  r_parity_err;
   logic                  r_overflow;

   logic [SYNC_WIDTH-1:0] w_hist_shift;
   logic [DATA_WIDTH-1:0] w_word_shift;
   logic                  w_sync_hit;
   logic                  w_shift_data;
   logic                  w_word_done;
   logic                  w_frame_done;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_done_word;
   logic                  w_done_perr;
   logic                  w_in_frame;

   // Shift helpers; width-1 registers simply take the new bit.
   generate
      if (SYNC_WIDTH == 1) begin : g_hist_w1
         assign w_hist_shift = din;
      end else begin : g_hist_wn
         assign w_hist_shift = {r_hist[SYNC_WIDTH-2:0], din};
      end
      if (DATA_WIDTH == 1) begin : g_word_w1
         assign w_word_shift = din;
      end else begin : g_word_wn
         assign w_word_shift = {r_word[DATA_WIDTH-2:0], din};
      end
   endgenerate

   assign w_sync_hit   = (r_state == S_HUNT) && din_valid && (w_hist_shift == SYNC_WORD);
   assign w_word_done  = (r_state == S_COLLECT) && din_valid && (r_bit_cnt == LAST_BIT);
   assign w_frame_done = w_word_done && (r_word_cnt == LAST_WORD);
   // A completed word lands if the register is empty or being drained this cycle.
   assign w_load       = w_word_done && (!r_dout_valid || dout_ready);

`ifdef PARITY_CHECK_EN
   // The trailing bit of each word is parity: it never enters the data register.
   assign w_shift_data = (r_bit_cnt < BCW'(DATA_WIDTH));
   assign w_done_word  = r_word;
   assign w_done_perr  = r_par ^ din;
`else
   assign w_shift_data = 1'b1;
   assign w_done_word  = w_word_shift;
   assign w_done_perr  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_HUNT;
      else         r_state <= w_state_next;
   end

   // Next-state: lock on the sync pattern, release after the last word of the frame.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_HUNT:    if (w_sync_hit)   w_state_next = S_COLLECT;
         S_COLLECT: if (w_frame_done) w_state_next = S_HUNT;
         default:                     w_state_next = S_HUNT;
      endcase
   end

   // State-derived outputs.
   always_comb begin
      w_in_frame = 1'b0;
      if (r_state == S_COLLECT) w_in_frame = 1'b1;
   end

   // Sync history, word shift register and bit/word counters; all hold when din_valid=0.
   // History is cleared at lock and stays clear through COLLECT, so hunting
   // after a frame always starts from an empty history.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hist     <= '0;
         r_word     <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
`ifdef PARITY_CHECK_EN
         r_par      <= 1'b0;
`endif
      end else if (din_valid) begin
         if (r_state == S_HUNT) begin
            if (w_sync_hit) begin
               r_hist     <= '0;
               r_word     <= '0;
               r_bit_cnt  <= '0;
               r_word_cnt <= '0;
`ifdef PARITY_CHECK_EN
               r_par      <= 1'b0;
`endif
            end else begin
               r_hist <= w_hist_shift;
            end
         end else begin
            if (w_shift_data) begin
               r_word <= w_word_shift;
`ifdef PARITY_CHECK_EN
               r_par  <= r_par ^ din;
`endif
            end
            if (w_word_done) begin
               r_bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
               r_par     <= 1'b0;
`endif
               if (w_frame_done) begin
                  r_word_cnt <= '0;
                  r_hist     <= '0;
               end else begin
                  r_word_cnt <= r_word_cnt + WCW'(1);
               end
            end else begin
               r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
         end
      end
   end

   // One-deep output register: load on completion when free, drop and flag otherwise.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_dout_last  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_overflow <= w_word_done && !w_load;
         if (w_load) begin
            r_dout       <= w_done_word;
            r_dout_valid <= 1'b1;
            r_dout_last  <= w_frame_done;
            r_parity_err <= w_done_perr;
         end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign dout_last  = r_dout_last;
   assign parity_err = r_parity_err;
   assign overflow   = r_overflow;
   assign in_frame   = w_in_frame;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer (default parameters). Optional build
// macro PARITY_CHECK_EN adds a parity bit after every payload word sent.
module tb_serial_frame_deserializer;

   localparam int         DW   = 16;
   localparam int         SW   = 8;
   localparam int         FW   = 4;
   localparam logic [7:0] SYNC = 8'hA5;
`ifdef PARITY_CHECK_EN
   localparam int WB = DW + 1;
`else
   localparam int WB = DW;
`endif

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          resetn;
   logic          din;
   logic          din_valid;
   logic          dout_ready;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_last;
   logic          parity_err;
   logic          overflow;
   logic          in_frame;

   always #5 clk = ~clk;

   serial_frame_deserializer dut (
      .clk        (clk),
      .resetn     (resetn),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .parity_err (parity_err),
      .overflow   (overflow),
      .in_frame   (in_frame)
   );

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;
   int ovf_cnt  = 0;
   logic cmp_en = 1'b0;
   logic g_rdy    = 1'b1;
   logic g_toggle = 1'b0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   logic          got_last_q[$];

   // ---------------- behavioural model ----------------
   // Stream-level view: hunting = last 8 accepted bits, locked = counting
   // payload bits into words; a finished word goes to a one-slot output.
   logic          m_locked;
   logic [7:0]    m_hist;
   logic [DW-1:0] m_cur;
   logic          m_par;
   int            m_nb;
   int            m_nw;
   logic [DW-1:0] m_dout;
   logic          m_valid;
   logic          m_last;
   logic          m_perr;
   logic          m_ovf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic v, input logic b, input logic rdy, input logic rn);
      logic          done;
      logic [DW-1:0] w;
      logic          last;
      logic          perr;
      logic          consumed;
      if (!rn) begin
         m_locked = 1'b0; m_hist = '0; m_cur = '0; m_par = 1'b0; m_nb = 0; m_nw = 0;
         m_dout = '0; m_valid = 1'b0; m_last = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
         return;
      end
      done     = 1'b0;
      w        = '0;
      last     = 1'b0;
      perr     = 1'b0;
      consumed = m_valid && rdy;
      m_ovf    = 1'b0;
      if (v) begin
         if (!m_locked) begin
            m_hist = {m_hist[6:0], b};
            if (m_hist == SYNC) begin
               m_locked = 1'b1; m_nb = 0; m_nw = 0; m_cur = '0; m_par = 1'b0;
            end
         end else begin
            if (m_nb < DW) m_cur = {m_cur[DW-2:0], b};
            m_par = m_par ^ b;
            m_nb++;
            if (m_nb == WB) begin
               done = 1'b1;
               w    = m_cur;
`ifdef PARITY_CHECK_EN
               perr = m_par;
`endif
               last = (m_nw == FW - 1);
               m_nb = 0; m_cur = '0; m_par = 1'b0; m_nw++;
               if (last) begin
                  m_locked = 1'b0; m_hist = '0;
               end
            end
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_dout = w; m_valid = 1'b1; m_last = last; m_perr = perr;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (consumed) begin
         m_valid = 1'b0;
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("dout_valid", 64'(dout_valid), 64'(m_valid));
         if (m_valid) begin
            check("dout", 64'(dout), 64'(m_dout));
            check("dout_last", 64'(dout_last), 64'(m_last));
            check("parity_err", 64'(parity_err), 64'(m_perr));
         end
         check("overflow", 64'(overflow), 64'(m_ovf));
         check("in_frame", 64'(in_frame), 64'(m_locked));
         if (overflow === 1'b1) ovf_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic v, input logic b, input logic rdy, input logic rn);
      din_valid  = v;
      din        = b;
      dout_ready = rdy;
      resetn     = rn;
      if (rn && dout_valid === 1'b1 && rdy) begin
         got_q.push_back(dout);
         got_last_q.push_back(dout_last);
      end
      @(posedge clk);
      model_edge(v, b, rdy, rn);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, g_rdy, 1'b1);
   endtask

   task automatic send_bits(input logic [63:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         if (g_toggle) step(1'b0, 1'b0, g_rdy, 1'b1);
         step(1'b1, val[i], g_rdy, 1'b1);
      end
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      send_bits(64'(w), DW);
`ifdef PARITY_CHECK_EN
      send_bits(64'(^w), 1);
`endif
   endtask

   task automatic send_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      send_bits(64'(SYNC), SW);
      send_word(w0);
      send_word(w1);
      send_word(w2);
      send_word(w3);
   endtask

   task automatic expect4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
   endtask

   task automatic check_log(input string name);
      check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check(name, 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      got_last_q.delete();
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1; resetn = 1'b0;

      // Reset values
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      check("rst_dout", 64'(dout), 64'h0);
      check("rst_dout_valid", 64'(dout_valid), 64'h0);
      check("rst_dout_last", 64'(dout_last), 64'h0);
      check("rst_parity_err", 64'(parity_err), 64'h0);
      check("rst_overflow", 64'(overflow), 64'h0);
      check("rst_in_frame", 64'(in_frame), 64'h0);
      cmp_en = 1'b1;
      idle(2);

      // Basic contiguous frame, consumer always ready
      send_frame(16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF);
      idle(3);
      check("basic_in_frame_after", 64'(in_frame), 64'h0);
      check("basic_last_n", 64'(got_last_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < got_last_q.size(); i++)
         check("basic_last_flag", 64'(got_last_q[i]), (i == 3) ? 64'h1 : 64'h0);
      expect4(16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF);
      check_log("basic_words");

      // Lock point: 1,0,1,0,0,1,0,1 is A5; the trailing 0,1 are payload
      begin
         logic [9:0] pre;
         pre = 10'b1010010101;
         for (int i = 9; i >= 0; i--) begin
            step(1'b1, pre[i], g_rdy, 1'b1);
            check("lock_point", 64'(in_frame), (i <= 2) ? 64'h1 : 64'h0);
         end
      end
      send_bits(64'h0ABC, 14);
`ifdef PARITY_CHECK_EN
      send_bits(64'(^16'h4ABC), 1);
`endif
      send_word(16'h1357);
      send_word(16'h2468);
      send_word(16'h9ACE);
      idle(3);
      expect4(16'h4ABC, 16'h1357, 16'h2468, 16'h9ACE);
      check_log("lock_words");

      // Sync patterns inside payload are plain data
      send_frame(16'hA5A5, 16'h00A5, 16'h5A5A, 16'hA500);
      idle(3);
      expect4(16'hA5A5, 16'h00A5, 16'h5A5A, 16'hA500);
      check_log("midsync_words");

      // Consumer stalled for the whole frame
      ovf_cnt = 0;
      g_rdy   = 1'b0;
      send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      idle(3);
      check("stall_dout", 64'(dout), 64'h1111);
      check("stall_valid", 64'(dout_valid), 64'h1);
      check("stall_last", 64'(dout_last), 64'h0);
      check("stall_overflows", 64'(ovf_cnt), 64'd3);
      g_rdy = 1'b1;
      idle(3);
      exp_q.push_back(16'h1111);
      check_log("stall_words");

      // din_valid toggling: same words at half rate
      g_toggle = 1'b1;
      send_frame(16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF);
      g_toggle = 1'b0;
      idle(3);
      expect4(16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF);
      check_log("toggle_words");

      // Reset after 9 payload bits, then a fresh frame
      send_bits(64'(SYNC), SW);
      send_bits(64'h1FF, 9);
      step(1'b1, 1'b1, g_rdy, 1'b0);
      check("midrst_in_frame", 64'(in_frame), 64'h0);
      check("midrst_valid", 64'(dout_valid), 64'h0);
      idle(1);
      send_frame(16'hCAFE, 16'h0F0F, 16'h8001, 16'h7E7E);
      idle(3);
      expect4(16'hCAFE, 16'h0F0F, 16'h8001, 16'h7E7E);
      check_log("midrst_words");

`ifdef PARITY_CHECK_EN
      // Parity: word 0003 with a wrong then a right parity bit
      g_rdy = 1'b0;
      send_bits(64'(SYNC), SW);
      send_bits(64'h0003, 16);
      send_bits(64'h1, 1);
      check("par_bad_dout", 64'(dout), 64'h0003);
      check("par_bad_err", 64'(parity_err), 64'h1);
      g_rdy = 1'b1;
      idle(1);
      send_bits(64'h0003, 16);
      send_bits(64'h0, 1);
      check("par_good_dout", 64'(dout), 64'h0003);
      check("par_good_err", 64'(parity_err), 64'h0);
      send_word(16'h0005);
      send_word(16'h0006);
      idle(3);
      expect4(16'h0003, 16'h0003, 16'h0005, 16'h0006);
      check_log("par_words");
`endif

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
